// File: rtl/filter_moving_avg_mux.sv
// Time-shared moving-average filter: per-channel holding registers, a
// round-robin scheduler and one shared accumulate/subtract datapath over a BRAM history.
module filter_moving_avg_mux #(
  parameter int NUM_CHANNELS  = 4,
  parameter int WINDOW_LENGTH = 64,
  parameter int INPUT_WIDTH   = 14,
  parameter int OUTPUT_WIDTH  = 16,
  localparam int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [NUM_CHANNELS-1:0]               i_input_valid,
  input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0]   i_input_data,
  output logic [NUM_CHANNELS-1:0]               o_input_ready,
  output logic                                  o_init_done,
  output logic                                  o_output_valid,
  output logic [CH_W-1:0]                       o_output_channel,
  output logic [OUTPUT_WIDTH-1:0]               o_output_data
);

  localparam int WIN_W       = $clog2(WINDOW_LENGTH);
  localparam int ACCUM_WIDTH = INPUT_WIDTH + WIN_W;
  localparam int ADDR_W      = CH_W + WIN_W;
  localparam int DEPTH       = NUM_CHANNELS * WINDOW_LENGTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                   r_state, w_state_next;
  logic [ADDR_W-1:0]        r_clr_addr;
  logic                     w_clearing;

  logic [NUM_CHANNELS-1:0]  r_pending;
  logic [INPUT_WIDTH-1:0]   r_hold [NUM_CHANNELS];
  logic [WIN_W-1:0]         r_wr_ptr [NUM_CHANNELS];
  logic [ACCUM_WIDTH-1:0]   r_accum [NUM_CHANNELS];
  logic [CH_W-1:0]          r_rr_ptr;

  logic                     w_grant_valid;
  logic [CH_W-1:0]          w_grant_ch;
  logic [ADDR_W-1:0]        w_rd_addr;

  logic                     r_s0_valid;
  logic [CH_W-1:0]          r_s0_ch;
  logic [INPUT_WIDTH-1:0]   r_s0_data;
  logic [ADDR_W-1:0]        r_s0_addr;

  logic [INPUT_WIDTH-1:0]   r_ram [DEPTH];
  logic [INPUT_WIDTH-1:0]   r_rd_data;
  logic                     w_ram_we;
  logic [ADDR_W-1:0]        w_ram_waddr;
  logic [INPUT_WIDTH-1:0]   w_ram_wdata;
  logic [ACCUM_WIDTH-1:0]   w_accum_new;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clearing   = 1'b0;
    o_init_done  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clearing = 1'b1;
        if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_state_next = S_RUN;
      end
      S_RUN:   o_init_done = 1'b1;
      default: w_state_next = S_CLEAR;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ready
    assign o_input_ready[gi] = o_init_done && !r_pending[gi];
  end

  // First pending channel at or after r_rr_ptr, wrapping through the index space.
  always_comb begin
    logic [CH_W-1:0] idx;
    w_grant_valid = 1'b0;
    w_grant_ch    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = r_rr_ptr + CH_W'(i);
      if (!w_grant_valid && r_pending[idx]) begin
        w_grant_valid = 1'b1;
        w_grant_ch    = idx;
      end
    end
  end

  assign w_rd_addr   = {w_grant_ch, r_wr_ptr[w_grant_ch]};
  assign w_accum_new = r_accum[r_s0_ch] + ACCUM_WIDTH'(r_s0_data) - ACCUM_WIDTH'(r_rd_data);
  assign w_ram_we    = w_clearing || r_s0_valid;
  assign w_ram_waddr = w_clearing ? r_clr_addr : r_s0_addr;
  assign w_ram_wdata = w_clearing ? '0 : r_s0_data;

  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
    r_rd_data <= r_ram[w_rd_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending        <= '0;
      r_rr_ptr         <= '0;
      r_s0_valid       <= 1'b0;
      r_s0_ch          <= '0;
      r_s0_data        <= '0;
      r_s0_addr        <= '0;
      o_output_valid   <= 1'b0;
      o_output_channel <= '0;
      o_output_data    <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_hold[c]   <= '0;
        r_wr_ptr[c] <= '0;
        r_accum[c]  <= '0;
      end
    end else begin
      // Accept and grant never coincide on a channel: one needs pending low, the other high.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (o_input_ready[c] && i_input_valid[c]) begin
          r_pending[c] <= 1'b1;
          r_hold[c]    <= i_input_data[c*INPUT_WIDTH +: INPUT_WIDTH];
        end else if (w_grant_valid && w_grant_ch == CH_W'(c)) begin
          r_pending[c] <= 1'b0;
          r_wr_ptr[c]  <= r_wr_ptr[c] + WIN_W'(1);
        end
        if (r_s0_valid && r_s0_ch == CH_W'(c)) r_accum[c] <= w_accum_new;
      end
      r_s0_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_rr_ptr  <= w_grant_ch + CH_W'(1);
        r_s0_ch   <= w_grant_ch;
        r_s0_data <= r_hold[w_grant_ch];
        r_s0_addr <= w_rd_addr;
      end
      o_output_valid <= r_s0_valid;
      if (r_s0_valid) begin
        o_output_channel <= r_s0_ch;
        o_output_data    <= w_accum_new[ACCUM_WIDTH-1 -: OUTPUT_WIDTH];
      end
    end
  end

endmodule

// File: doc/filter_moving_avg_mux.md
# filter_moving_avg_mux

Time-shared moving-average filter for NUM_CHANNELS independent magnitude streams. Per-channel input holding registers feed a round-robin scheduler, which issues at most one sample per cycle into a single shared accumulate/subtract datapath. The datapath keeps a per-channel circular history in one block RAM. The block sits between the per-channel magnitude stages and downstream threshold/detection logic. It replaces NUM_CHANNELS separate filter_moving_avg instances.

## Interface
- NUM_CHANNELS, 4: number of input streams; power of 2, ≥ 2.
- WINDOW_LENGTH, 64: samples per average; power of 2, ≥ 2.
- INPUT_WIDTH, 14: unsigned input sample width.
- OUTPUT_WIDTH, 16: output width; must be ≤ ACCUM_WIDTH = INPUT_WIDTH + clog2(WINDOW_LENGTH).

Ports:
- Clk  in  1  sole clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Input_valid  in  NUM_CHANNELS  per-channel sample strobe.
- Input_data  in  NUM_CHANNELS x INPUT_WIDTH  per-channel sample.
- Input_ready  out  NUM_CHANNELS  per-channel accept; a transfer occurs when valid && ready at a rising edge.
- Init_done  out  1  high once history clearing is complete.
- Output_valid  out  1  one-cycle result strobe.
- Output_channel  out  clog2(NUM_CHANNELS)  channel of the current result.
- Output_data  out  OUTPUT_WIDTH  averaged result.

## Operation
- FSM states are S_CLEAR and S_RUN.
  - S_CLEAR is entered on reset. It writes zero to every RAM entry (NUM_CHANNELS*WINDOW_LENGTH writes, one per cycle, address 0 upward). It then moves to S_RUN and sets Init_done.
  - Input_ready is all-zero in S_CLEAR.
- Holding register per channel: a data register plus a pending bit.
  - Input_ready[c] = S_RUN && !pending[c].
  - An accepted sample sets pending[c].
  - A grant to channel c clears pending[c].
  - A channel can therefore be accepted at most every other cycle.
- Scheduler:
  - Each cycle, grant the first pending channel at or after rr_ptr, searching in increasing index with wrap.
  - After a grant, rr_ptr = granted+1 mod NUM_CHANNELS.
  - No grant is made when nothing is pending.
- Datapath, 2 stages:
  - Stage 0 (grant cycle): present RAM read address c*WINDOW_LENGTH + wr_ptr[c]. Register the sample, channel and valid. Set wr_ptr[c] = wr_ptr[c]+1, wrapping at WINDOW_LENGTH.
  - Stage 1: old = RAM read data. Compute accum_new = accum[c] + new - old, in ACCUM_WIDTH bits; this is exact because it never overflows. Write new to the same address, set accum[c] = accum_new, and register the outputs.
- Output_data = accum_new[ACCUM_WIDTH-1 -: OUTPUT_WIDTH], i.e. MSB truncation; the sum is divided by 2^(ACCUM_WIDTH-OUTPUT_WIDTH).
- Back-to-back grants to the same channel never happen, because pending needs a refill cycle. Accumulator update and RAM address are therefore hazard-free without forwarding.
- Reset at any time (Rst_n low):
  - Asynchronously clears pending, accum, wr_ptr, rr_ptr, pipeline valids and outputs.
  - In-flight samples are dropped.
  - The FSM re-enters S_CLEAR.

## Timing
- Reset values:
  - Input_ready = 0.
  - Init_done = 0.
  - Output_valid = 0.
  - Output_channel = 0.
  - Output_data = 0.
  - rr_ptr = 0.
- S_CLEAR lasts exactly NUM_CHANNELS*WINDOW_LENGTH cycles after Rst_n deasserts. Init_done and Input_ready rise on the following edge.
- Latency, uncontended: for a sample accepted at edge E0, the grant occurs in the cycle after E0. Output_valid is high in the cycle following edge E0+2.
- Contended: extra delay is at most NUM_CHANNELS-1 cycles.
- Throughput: one result per cycle in aggregate; one per 2 cycles per channel.
- Output_valid is high for exactly one cycle per accepted sample. Results of one channel appear in acceptance order.
- Output_channel and Output_data are held between strobes.

## Test plan
- Reset release: Init_done and every Input_ready bit stay 0 for 256 cycles (4x64), then go to 1. All outputs stay 0 throughout.
- Channel 0 receives constant 1000 for 100 samples: the k-th output is (1000*k)>>4 for k ≤ 64, then holds at 4000. Other channels produce no output.
- All channels receive 16383 continuously: every channel saturates its window at output 0xFFFC, with no wrap or overflow.
- All 4 channels assert valid on the same edge immediately after Init_done: grants and Output_channel sequence are 0,1,2,3 on consecutive cycles. Sustained traffic keeps the rotation fair (no channel twice before all others once).
- Random per-channel data with random valid gaps for 10000 samples per channel, against a per-channel scoreboard model: every result matches, with no cross-channel contamination.
- Rst_n pulsed low mid-stream with pending and in-flight samples: outputs go to 0 immediately with no further strobes and the 256-cycle clear repeats. The first post-reset sample d on any channel yields d>>4.
